// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush controller for a 5-stage RV32I pipeline. Drives the
// enables and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB buffer
// registers and the PC. It handles three conditions:
//   * load-use hazards (one-cycle stall plus a bubble into EX)
//   * taken branches (flush IF/ID and ID/EX)
//   * multicycle data-memory accesses (freeze the whole pipeline)
// A watchdog halts the core if a memory access hangs longer than MEM_TIMEOUT.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   When defined, adds the performance counters stall_cycles, flush_count and
//   timeout_count. When undefined, those ports and their logic are absent.
//
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   ifid_rs1/rs2      source registers of the instruction in ID
//   ifid_uses_rs2     instruction in ID actually reads rs2
//   idex_rd           destination register of the instruction in EX
//   idex_memread      instruction in EX is a load
//   ex_branch_taken   branch/jump resolved taken in EX this cycle
//   mem_req           instruction in MEM accesses data memory
//   mem_ready         data memory completes the access this cycle
//   pc_write, ifid_write, idex_write, exmem_write   register enables
//   ifid_flush, idex_flush, memwb_bubble            flush/bubble controls
//   halted            sticky watchdog fault
//   stall_state       FSM state (0=RUN, 1=MEM_WAIT, 2=HALT)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    input  logic        ifid_uses_rs2,
    input  logic [4:0]  idex_rd,
    input  logic        idex_memread,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_write,
    output logic        idex_flush,
    output logic        exmem_write,
    output logic        memwb_bubble,
    output logic        halted,
    output logic [1:0]  stall_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic [7:0]  timeout_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               halted_q, halted_d;

    logic               load_use;
    logic               mem_wait;
    logic               run_rules;
    logic               branch_flush;
    logic               lu_stall;

    // Hazard detection on the current inputs. x0 is never a real dependency.
    always_comb begin
        load_use = idex_memread && (idex_rd != 5'd0) &&
                   ((idex_rd == ifid_rs1) ||
                    (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
        mem_wait = mem_req && !mem_ready;
    end

    // Next-state and output logic.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        halted_d     = halted_q;
        run_rules    = 1'b0;
        branch_flush = 1'b0;
        lu_stall     = 1'b0;

        case (state_q)
            ST_RUN: begin
                run_rules = 1'b1;
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    // Freeze drops in the completing cycle so the access
                    // retires without an extra dead cycle.
                    run_rules  = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_write  = 1'b0;
                    memwb_bubble = 1'b1;
                    if (wait_cnt_q == TIMEOUT_CNT) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_ONE;
                    end
                end
            end
            ST_HALT: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_write  = 1'b0;
                memwb_bubble = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // RUN priority: memory wait > branch flush > load-use.
        if (run_rules) begin
            if (mem_wait) begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_write  = 1'b0;
                memwb_bubble = 1'b1;
                state_d      = ST_MEM_WAIT;
                wait_cnt_d   = CNT_ONE;
            end else if (ex_branch_taken) begin
                // The flush also removes a dependent instruction in ID, so
                // a simultaneous load-use needs no stall.
                ifid_flush   = 1'b1;
                idex_flush   = 1'b1;
                branch_flush = 1'b1;
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
                lu_stall   = 1'b1;
            end
        end

        // The reset cycle presents a free-running pipeline regardless of the
        // state left behind.
        if (reset) begin
            pc_write     = 1'b1;
            ifid_write   = 1'b1;
            ifid_flush   = 1'b0;
            idex_write   = 1'b1;
            idex_flush   = 1'b0;
            exmem_write  = 1'b1;
            memwb_bubble = 1'b0;
            branch_flush = 1'b0;
            lu_stall     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            halted_q   <= halted_d;
        end
    end

    assign halted      = halted_q;
    assign stall_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q,  flush_count_d;
    logic [7:0]  timeout_count_q, timeout_count_d;

    // A MEM_WAIT exit cycle that also stalls on load-use counts once.
    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        flush_count_d   = flush_count_q;
        timeout_count_d = timeout_count_q;
        if ((state_q == ST_MEM_WAIT) || lu_stall)
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (branch_flush)
            flush_count_d = flush_count_q + 32'd1;
        if ((state_q != ST_HALT) && (state_d == ST_HALT))
            timeout_count_d = timeout_count_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q  <= '0;
            flush_count_q   <= '0;
            timeout_count_q <= '0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            flush_count_q   <= flush_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign flush_count   = flush_count_q;
    assign timeout_count = timeout_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
    logic       ifid_uses_rs2, idex_memread, ex_branch_taken, mem_req, mem_ready;
    logic       pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic       exmem_write, memwb_bubble, halted;
    logic [1:0] stall_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
    logic [7:0]  timeout_count;
`endif

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
        .idex_rd(idex_rd), .idex_memread(idex_memread),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
        .memwb_bubble(memwb_bubble), .halted(halted), .stall_state(stall_state)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count),
        .timeout_count(timeout_count)
`endif
    );

    always #5 clk = ~clk;

    // Output vector {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, bubble}
    localparam logic [6:0] O_RUN = 7'b1101010;
    localparam logic [6:0] O_FRZ = 7'b0000001;
    localparam logic [6:0] O_BR  = 7'b1111110;
    localparam logic [6:0] O_LU  = 7'b0001110;

    typedef struct {
        logic       memread;
        logic [4:0] rd, rs1, rs2;
        logic       uses2, br, req, rdy;
        logic [6:0] exp;
    } vec_t;

    int nchk = 0;
    int nerr = 0;

    function automatic logic [6:0] outs();
        return {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                exmem_write, memwb_bubble};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u, input logic br,
                         input logic req, input logic rdy);
        idex_memread = mr; idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2;
        ifid_uses_rs2 = u; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
        vecs[1] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[2] = '{1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
        vecs[3] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN};
        vecs[4] = '{1'b1, 5'd3, 5'd1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
        vecs[5] = '{1'b1, 5'd3, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[6] = '{1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_BR};
        vecs[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_BR};
        vecs[8] = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_LU};
        vecs[9] = '{1'b1, 5'd5, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};

        reset = 1'b1;
        idle();
        // Outputs during the reset cycle.
        chk("reset_cycle_outs", 32'(outs()), 32'(O_RUN));
        tick();
        reset = 1'b0;
        #1;
        chk("reset_state", 32'(stall_state), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);

        // Single-cycle RUN vectors; state must remain RUN throughout.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].memread, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].uses2, vecs[i].br, vecs[i].req, vecs[i].rdy);
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
            tick();
            chk($sformatf("vec%0d_state", i), 32'(stall_state), 32'd0);
        end
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_flush_after_table", flush_count, 32'd2);
        chk("perf_stall_after_table", stall_cycles, 32'd4);
`endif

        // Memory wait: ready low for 3 cycles then high.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mw_detect_outs", 32'(outs()), 32'(O_FRZ));
        tick();
        // Branch in MEM_WAIT must be ignored.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("mw1_state", 32'(stall_state), 32'd1);
        chk("mw1_outs_branch_ignored", 32'(outs()), 32'(O_FRZ));
        tick();
        chk("mw2_state", 32'(stall_state), 32'd1);
        chk("mw2_outs", 32'(outs()), 32'(O_FRZ));
        tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("mw3_state", 32'(stall_state), 32'd1);
        chk("mw_ready_outs", 32'(outs()), 32'(O_RUN));
        tick();
        idle();
        chk("mw_exit_state", 32'(stall_state), 32'd0);

        // MEM_WAIT exit cycle applies load-use to current inputs.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("mw_exit_lu_outs", 32'(outs()), 32'(O_LU));
        tick();
        idle();
        chk("mw_exit_lu_state", 32'(stall_state), 32'd0);

        // Reset mid-wait with wait_cnt=2.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        chk("rmw_pre_state", 32'(stall_state), 32'd1);
        reset = 1'b1;
        #1;
        chk("rmw_reset_cycle_outs", 32'(outs()), 32'(O_RUN));
        tick();
        reset = 1'b0;
        idle();
        chk("rmw_state", 32'(stall_state), 32'd0);
        chk("rmw_outs", 32'(outs()), 32'(O_RUN));
`ifdef HAZARD_PERF_CNT_EN
        chk("rmw_stall_cycles", stall_cycles, 32'd0);
        chk("rmw_flush_count", flush_count, 32'd0);
        chk("rmw_timeout_count", 32'(timeout_count), 32'd0);
`endif

        // Timeout: wait_cnt enters at 1 and HALT follows the cycle it equals T.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= T; k++) begin
            chk($sformatf("to_wait%0d_state", k), 32'(stall_state), 32'd1);
            chk($sformatf("to_wait%0d_halted", k), 32'(halted), 32'd0);
            tick();
        end
        chk("to_halt_state", 32'(stall_state), 32'd2);
        chk("to_halt_halted", 32'(halted), 32'd1);
        chk("to_halt_outs", 32'(outs()), 32'(O_FRZ));
`ifdef HAZARD_PERF_CNT_EN
        chk("to_timeout_count", 32'(timeout_count), 32'd1);
        chk("to_stall_cycles", stall_cycles, 32'(T));
`endif
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("halt_ready_state", 32'(stall_state), 32'd2);
        chk("halt_ready_halted", 32'(halted), 32'd1);
        chk("halt_ready_outs", 32'(outs()), 32'(O_FRZ));

        idle();
        do_reset();
        chk("halt_reset_state", 32'(stall_state), 32'd0);
        chk("halt_reset_halted", 32'(halted), 32'd0);
        chk("halt_reset_outs", 32'(outs()), 32'(O_RUN));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
